// File: rtl/eth_check_pkg.sv
// Shared types and helpers for the RX packet checker.
// Optional feature macro used elsewhere in this slice: RX_PKT_CHECK_FIRST_ERR_EN.
package eth_check_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } check_state_t;

  localparam int PATTERN_MOD = 256;
  localparam int PATTERN_W   = $clog2(PATTERN_MOD);
  localparam int MAX_KEEP_W  = 64;

  function automatic logic [7:0] popcount_keep(input logic [MAX_KEEP_W-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      cnt = cnt + 8'(keep[i]);
    end
    return cnt;
  endfunction

  // True when keep has the form 2^k-1; an all-zero mask also passes, so callers test non-zero separately.
  function automatic logic keep_contiguous(input logic [MAX_KEEP_W-1:0] keep);
    return ((keep & (keep + MAX_KEEP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/rx_pattern_lane_cmp.sv
// Per-beat payload compare: each kept lane j must carry (base + j) mod 256.
// Reports the mismatch mask and the lowest mismatching lane.
module rx_pattern_lane_cmp
  import eth_check_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int KEEP_W = DATA_W / 8,
  localparam int LANE_W = (KEEP_W > 1) ? $clog2(KEEP_W) : 1
) (
  input  logic [DATA_W-1:0]    i_data,
  input  logic [KEEP_W-1:0]    i_keep,
  input  logic [PATTERN_W-1:0] i_base,
  output logic [KEEP_W-1:0]    o_mismatch,
  output logic [LANE_W-1:0]    o_first_lane
);

  always_comb begin
    o_mismatch = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      o_mismatch[j] = i_keep[j] &&
                      (i_data[8*j +: 8] != (i_base + PATTERN_W'(j)));
    end
  end

  always_comb begin
    o_first_lane = '0;
    for (int j = KEEP_W - 1; j >= 0; j--) begin
      if (o_mismatch[j]) o_first_lane = LANE_W'(j);
    end
  end

endmodule

// File: rtl/rx_packet_checker.sv
// Checks MAC RX frames against the incrementing-byte payload pattern, expected length and FCS flag.
// Optional first-error capture ports are enabled by RX_PKT_CHECK_FIRST_ERR_EN.
module rx_packet_checker
  import eth_check_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int LEN_W     = 16,
  parameter  int CNT_W     = 32,
  parameter  int ERR_CNT_W = 16,
  localparam int KEEP_W    = DATA_W / 8,
  localparam int LANE_W    = (KEEP_W > 1) ? $clog2(KEEP_W) : 1
) (
  input  logic                 i_rx_clk,
  input  logic                 i_rx_reset,
  input  logic                 s_axis_tvalid,
  input  logic [KEEP_W-1:0]    s_axis_tkeep,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  input  logic [9:0]           i_expected_bytes,
  input  logic                 i_clear,
  output logic [CNT_W-1:0]     o_pkt_count,
  output logic [CNT_W-1:0]     o_byte_count,
  output logic [ERR_CNT_W-1:0] o_err_pattern_count,
  output logic [ERR_CNT_W-1:0] o_err_len_count,
  output logic [ERR_CNT_W-1:0] o_err_fcs_count,
  output logic                 o_pkt_done,
  output logic                 o_pkt_ok
`ifdef RX_PKT_CHECK_FIRST_ERR_EN
  ,
  output logic                 o_first_err_valid,
  output logic [CNT_W-1:0]     o_first_err_pkt,
  output logic [LEN_W-1:0]     o_first_err_offset
`endif
);

  check_state_t         r_state;
  logic [LEN_W-1:0]     r_offset;
  logic [LEN_W-1:0]     r_len;
  logic                 r_err_pat;
  logic [CNT_W-1:0]     r_pkt_count;
  logic [CNT_W-1:0]     r_byte_count;
  logic [ERR_CNT_W-1:0] r_err_pat_count;
  logic [ERR_CNT_W-1:0] r_err_len_count;
  logic [ERR_CNT_W-1:0] r_err_fcs_count;
  logic                 r_pkt_done;
  logic                 r_pkt_ok;

  logic                  w_sop;
  logic [LEN_W-1:0]      w_base;
  logic [LEN_W-1:0]      w_len_base;
  logic [LEN_W:0]        w_len_sum;
  logic [LEN_W-1:0]      w_len_next;
  logic [MAX_KEEP_W-1:0] w_keep_ext;
  logic [7:0]            w_pop;
  logic                  w_keep_err;
  logic [KEEP_W-1:0]     w_mismatch;
  logic [LANE_W-1:0]     w_first_lane;
  logic                  w_beat_pat;
  logic                  w_pat_flag;
  logic                  w_len_err;
  logic                  w_frame_end;

  // Any beat seen in IDLE is a start of packet, so per-frame state is rebased here.
  assign w_sop      = (r_state == IDLE);
  assign w_base     = w_sop ? '0 : r_offset;
  assign w_len_base = w_sop ? '0 : r_len;
  assign w_keep_ext = MAX_KEEP_W'(s_axis_tkeep);
  assign w_pop      = popcount_keep(w_keep_ext);
  assign w_len_sum  = {1'b0, w_len_base} + (LEN_W + 1)'(w_pop);
  assign w_len_next = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];

  assign w_keep_err = s_axis_tlast ? ((s_axis_tkeep == '0) || !keep_contiguous(w_keep_ext))
                                   : !(&s_axis_tkeep);

  rx_pattern_lane_cmp #(.DATA_W(DATA_W)) u_lane_cmp (
    .i_data       (s_axis_tdata),
    .i_keep       (s_axis_tkeep),
    .i_base       (w_base[PATTERN_W-1:0]),
    .o_mismatch   (w_mismatch),
    .o_first_lane (w_first_lane)
  );

  assign w_beat_pat  = (|w_mismatch) | w_keep_err;
  assign w_pat_flag  = (!w_sop && r_err_pat) || w_beat_pat;
  assign w_len_err   = (i_expected_bytes != '0) && (w_len_next != LEN_W'(i_expected_bytes));
  assign w_frame_end = s_axis_tvalid && s_axis_tlast;

  always_ff @(posedge i_rx_clk or posedge i_rx_reset) begin
    if (i_rx_reset) begin
      r_state         <= IDLE;
      r_offset        <= '0;
      r_len           <= '0;
      r_err_pat       <= 1'b0;
      r_pkt_count     <= '0;
      r_byte_count    <= '0;
      r_err_pat_count <= '0;
      r_err_len_count <= '0;
      r_err_fcs_count <= '0;
      r_pkt_done      <= 1'b0;
      r_pkt_ok        <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_pkt_ok   <= 1'b0;
      if (s_axis_tvalid) begin
        r_offset  <= w_base + LEN_W'(w_pop);
        r_len     <= w_len_next;
        r_err_pat <= w_pat_flag;
        if (s_axis_tlast) begin
          r_state    <= IDLE;
          r_pkt_done <= 1'b1;
          r_pkt_ok   <= !(w_pat_flag || w_len_err || s_axis_tuser);
        end else begin
          r_state <= IN_PKT;
        end
      end

      // Clear wins over same-cycle increments but leaves the in-flight frame alone.
      if (i_clear) begin
        r_pkt_count     <= '0;
        r_byte_count    <= '0;
        r_err_pat_count <= '0;
        r_err_len_count <= '0;
        r_err_fcs_count <= '0;
      end else begin
        if (s_axis_tvalid) r_byte_count <= r_byte_count + CNT_W'(w_pop);
        if (w_frame_end) begin
          r_pkt_count <= r_pkt_count + CNT_W'(1);
          if (w_pat_flag && (r_err_pat_count != '1))
            r_err_pat_count <= r_err_pat_count + ERR_CNT_W'(1);
          if (w_len_err && (r_err_len_count != '1))
            r_err_len_count <= r_err_len_count + ERR_CNT_W'(1);
          if (s_axis_tuser && (r_err_fcs_count != '1))
            r_err_fcs_count <= r_err_fcs_count + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign o_pkt_count         = r_pkt_count;
  assign o_byte_count        = r_byte_count;
  assign o_err_pattern_count = r_err_pat_count;
  assign o_err_len_count     = r_err_len_count;
  assign o_err_fcs_count     = r_err_fcs_count;
  assign o_pkt_done          = r_pkt_done;
  assign o_pkt_ok            = r_pkt_ok;

`ifdef RX_PKT_CHECK_FIRST_ERR_EN
  logic             r_first_err_valid;
  logic [CNT_W-1:0] r_first_err_pkt;
  logic [LEN_W-1:0] r_first_err_offset;

  // A tkeep violation has no single bad lane, so it is pinned to the beat's lane 0.
  always_ff @(posedge i_rx_clk or posedge i_rx_reset) begin
    if (i_rx_reset) begin
      r_first_err_valid  <= 1'b0;
      r_first_err_pkt    <= '0;
      r_first_err_offset <= '0;
    end else if (i_clear) begin
      r_first_err_valid  <= 1'b0;
      r_first_err_pkt    <= '0;
      r_first_err_offset <= '0;
    end else if (s_axis_tvalid && w_beat_pat && !r_first_err_valid) begin
      r_first_err_valid  <= 1'b1;
      r_first_err_pkt    <= r_pkt_count;
      r_first_err_offset <= w_keep_err ? w_base : (w_base + LEN_W'(w_first_lane));
    end
  end

  assign o_first_err_valid  = r_first_err_valid;
  assign o_first_err_pkt    = r_first_err_pkt;
  assign o_first_err_offset = r_first_err_offset;
`else
  logic w_unused_first_lane;
  assign w_unused_first_lane = ^w_first_lane;
`endif

endmodule
